// File: rtl/serial_alu_pkg.sv
// Shared definitions for the serial add/subtract unit.
//   OP_ADD / OP_SUB : operation select encoding on the op input.
//   state_e         : control FSM state encoding.
//   cnt_width()     : width of the slice counter, never below one bit.
package serial_alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// Combinational SLICE-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a_i, b_i  : SLICE-bit operand slices (b_i is already inverted for subtract)
//   cin_i     : carry into bit 0 of the slice
//   sum_o     : SLICE-bit sum
//   cout_o    : carry out of the top bit of the slice
//   cmsb_o    : carry into the top bit of the slice (used for signed overflow)
module add_sub_slice #(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [SLICE:0] carry;

    assign carry[0] = cin_i;

    for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
        assign sum_o[gi]    = a_i[gi] ^ b_i[gi] ^ carry[gi];
        assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end

    assign cout_o = carry[SLICE];
    assign cmsb_o = carry[SLICE-1];

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: processes a WIDTH-bit operand pair SLICE bits
// per clock, LSB slice first, with the inter-slice carry held in a register.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only when idle)
//   a, b, op            : operands and operation (0 = add, 1 = subtract)
//   out_valid/out_ready : result handshake
//   result              : WIDTH-bit two's complement sum/difference
//   carryout            : carry out of the MSB (subtract: 1 = no borrow)
//   overflow            : signed overflow (carry into MSB ^ carry out of MSB)
//   zero                : result == 0
module serial_add_sub
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    if ((WIDTH < 2) || (SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
        $error("serial_add_sub: WIDTH must be >= 2 and SLICE must divide WIDTH");
    end

    localparam int NSLICES = WIDTH / SLICE;
    localparam int CW      = cnt_width(NSLICES);
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICES - 1);

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             carryout_q;
    logic             overflow_q;
    logic             zero_q;

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] shift_d;

    add_sub_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i    (a_q[SLICE-1:0]),
        .b_i    (b_q[SLICE-1:0]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout),
        .cmsb_o (slice_cmsb)
    );

    // New slice enters from the top while older bits move down; after the
    // final slice the LSB slice has arrived at bit 0. When SLICE == WIDTH the
    // right shift clears sum_q entirely, so the slice sum is the whole result.
    assign shift_d = (WIDTH'(slice_sum) << (WIDTH - SLICE)) | (sum_q >> SLICE);

    // The visible result is a separate register loaded only on the final
    // slice, so result and flags stay stable while the next operation runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= (op == OP_SUB) ? ~b : b;
                        // Subtract is A + ~B + 1: the +1 rides in as the initial carry.
                        carry_q    <= (op != OP_ADD);
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    sum_q   <= shift_d;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_SLICE) begin
                        result_q    <= shift_d;
                        carryout_q  <= slice_cout;
                        overflow_q  <= slice_cmsb ^ slice_cout;
                        zero_q      <= (shift_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carryout  = carryout_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub at WIDTH=8 with two instances: SLICE=1 (index 0)
// and SLICE=4 (index 1). Expected results are queued when an operation is
// issued; a monitor pops and compares on every output handshake.
module tb_serial_add_sub;
    import serial_alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid_s  [2];
    logic         in_ready_s  [2];
    logic [W-1:0] a_s         [2];
    logic [W-1:0] b_s         [2];
    logic         op_s        [2];
    logic         out_valid_s [2];
    logic         out_ready_s [2];
    logic [W-1:0] result_s    [2];
    logic         carryout_s  [2];
    logic         overflow_s  [2];
    logic         zero_s      [2];

    int n_cmp = 0;
    int n_bad = 0;

    vec_t q0[$];
    vec_t q1[$];

    // Hand-computed vectors: {a, b, op, result, carryout, overflow, zero}
    vec_t vecs0 [8] = '{
        '{8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b1, 1'b0},
        '{8'h05, 8'h05, OP_SUB, 8'h00, 1'b1, 1'b0, 1'b1},
        '{8'h00, 8'h01, OP_SUB, 8'hFF, 1'b0, 1'b0, 1'b0},
        '{8'h80, 8'h01, OP_SUB, 8'h7F, 1'b1, 1'b1, 1'b0},
        '{8'hFF, 8'hFF, OP_ADD, 8'hFE, 1'b1, 1'b0, 1'b0},
        '{8'h80, 8'h80, OP_ADD, 8'h00, 1'b1, 1'b1, 1'b1},
        '{8'h7F, 8'hFF, OP_SUB, 8'h80, 1'b0, 1'b1, 1'b0},
        '{8'h3C, 8'h0F, OP_ADD, 8'h4B, 1'b0, 1'b0, 1'b0}
    };
    vec_t vecs1 [5] = '{
        '{8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b0, 1'b1},
        '{8'h12, 8'h34, OP_ADD, 8'h46, 1'b0, 1'b0, 1'b0},
        '{8'h01, 8'h02, OP_SUB, 8'hFF, 1'b0, 1'b0, 1'b0},
        '{8'h7F, 8'h7F, OP_ADD, 8'hFE, 1'b0, 1'b1, 1'b0},
        '{8'hC8, 8'h64, OP_SUB, 8'h64, 1'b1, 1'b1, 1'b0}
    };

    serial_add_sub #(.WIDTH(W), .SLICE(1)) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_s[0]),
        .in_ready  (in_ready_s[0]),
        .a         (a_s[0]),
        .b         (b_s[0]),
        .op        (op_s[0]),
        .out_valid (out_valid_s[0]),
        .out_ready (out_ready_s[0]),
        .result    (result_s[0]),
        .carryout  (carryout_s[0]),
        .overflow  (overflow_s[0]),
        .zero      (zero_s[0])
    );

    serial_add_sub #(.WIDTH(W), .SLICE(4)) u_s4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_s[1]),
        .in_ready  (in_ready_s[1]),
        .a         (a_s[1]),
        .b         (b_s[1]),
        .op        (op_s[1]),
        .out_valid (out_valid_s[1]),
        .out_ready (out_ready_s[1]),
        .result    (result_s[1]),
        .carryout  (carryout_s[1]),
        .overflow  (overflow_s[1]),
        .zero      (zero_s[1])
    );

    always #5 clk = ~clk;

    // Independent reference: full-width sum of A and the (possibly inverted) B.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        vec_t         v;
        logic [W-1:0] bb;
        logic [W:0]   s;
        bb   = op ? ~b : b;
        s    = {1'b0, a} + {1'b0, bb} + (W+1)'(op);
        v.a  = a;
        v.b  = b;
        v.op = op;
        v.r  = s[W-1:0];
        v.co = s[W];
        v.ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        v.z  = (s[W-1:0] == '0);
        return v;
    endfunction

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    task automatic check_out(input int k);
        vec_t       e;
        logic [W+2:0] got;
        logic [W+2:0] want;
        got = {result_s[k], carryout_s[k], overflow_s[k], zero_s[k]};
        n_cmp++;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            n_bad++;
            $display("FAIL unexpected_output dut%0d: got r=%h co=%b ov=%b z=%b, expected no output",
                     k, result_s[k], carryout_s[k], overflow_s[k], zero_s[k]);
            return;
        end
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        want = {e.r, e.co, e.ov, e.z};
        if (got !== want) begin
            n_bad++;
            $display("FAIL result dut%0d a=%h b=%h op=%b: got r=%h co=%b ov=%b z=%b, expected r=%h co=%b ov=%b z=%b",
                     k, e.a, e.b, e.op, result_s[k], carryout_s[k], overflow_s[k], zero_s[k],
                     e.r, e.co, e.ov, e.z);
        end else begin
            $display("tx dut%0d a=%h b=%h op=%b -> r=%h co=%b ov=%b z=%b ok",
                     k, e.a, e.b, e.op, result_s[k], carryout_s[k], overflow_s[k], zero_s[k]);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (out_valid_s[k] && out_ready_s[k]) check_out(k);
            end
        end
    end

    // Called and returning at posedge+1; returns just after the accept edge.
    task automatic send(input int k, input vec_t v, input bit push);
        int n = 0;
        while (!in_ready_s[k] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready_s[k]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout dut%0d: in_ready=%b after %0d cycles, expected 1", k, in_ready_s[k], n);
            return;
        end
        if (push) begin
            if (k == 0) q0.push_back(v);
            else        q1.push_back(v);
        end
        a_s[k]        = v.a;
        b_s[k]        = v.b;
        op_s[k]       = v.op;
        in_valid_s[k] = 1'b1;
        @(posedge clk); #1;
        in_valid_s[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int n);
        n = 0;
        while (!out_valid_s[k] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int   n;
        vec_t v;
        for (int k = 0; k < 2; k++) begin
            in_valid_s[k]  = 1'b0;
            a_s[k]         = '0;
            b_s[k]         = '0;
            op_s[k]        = 1'b0;
            out_ready_s[k] = 1'b1;
        end

        // Reset with in_valid asserted: the request must be ignored.
        reset         = 1'b1;
        in_valid_s[0] = 1'b1;
        a_s[0]        = 8'h11;
        b_s[0]        = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            expect_eq($sformatf("reset_state_dut%0d", k),
                      32'({in_ready_s[k], out_valid_s[k], result_s[k], carryout_s[k], overflow_s[k], zero_s[k]}),
                      32'h1000);
        end
        reset         = 1'b0;
        in_valid_s[0] = 1'b0;

        // SLICE=1 directed vectors; first one also measures latency.
        send(0, vecs0[0], 1'b1);
        wait_valid(0, n);
        expect_eq("latency_slice1", n, 8);
        for (int i = 1; i < 8; i++) send(0, vecs0[i], 1'b1);

        // SLICE=4 directed vectors; first one also measures latency.
        send(1, vecs1[0], 1'b1);
        wait_valid(1, n);
        expect_eq("latency_slice4", n, 2);
        for (int i = 1; i < 5; i++) send(1, vecs1[i], 1'b1);

        // A few random pairs against the reference model on both instances.
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 2; k++) begin
                v = model(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
                send(k, v, 1'b1);
            end
        end

        // Backpressure on the SLICE=1 instance.
        wait_valid(0, n);
        @(posedge clk); #1;
        out_ready_s[0] = 1'b0;
        send(0, vecs0[7], 1'b1);
        wait_valid(0, n);
        for (int i = 0; i < 5; i++) begin
            in_valid_s[0] = 1'b1;
            a_s[0]        = 8'h11;
            b_s[0]        = 8'h22;
            op_s[0]       = OP_ADD;
            @(posedge clk); #1;
            expect_eq($sformatf("backpressure_hold_%0d", i),
                      32'({out_valid_s[0], in_ready_s[0], result_s[0]}), 32'h24B);
        end
        in_valid_s[0]  = 1'b0;
        out_ready_s[0] = 1'b1;
        @(posedge clk); #1;
        expect_eq("release_to_idle", 32'({out_valid_s[0], in_ready_s[0]}), 32'h1);
        repeat (12) @(posedge clk);
        #1;

        // Reset in the middle of RUN (slice counter at 3): no output expected.
        send(0, '{8'hAA, 8'h55, OP_ADD, 8'hFF, 1'b0, 1'b0, 1'b0}, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        expect_eq("reset_mid_run",
                  32'({in_ready_s[0], out_valid_s[0], result_s[0], carryout_s[0], overflow_s[0], zero_s[0]}),
                  32'h1000);
        reset = 1'b0;
        send(0, '{8'h12, 8'h34, OP_ADD, 8'h46, 1'b0, 1'b0, 1'b0}, 1'b1);
        wait_valid(0, n);

        // Drain both scoreboards (bounded).
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        expect_eq("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
